// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - queued rectangle-fill rasteriser feeding vga_adapter, one pixel per clock.

module rect_fill_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

module rect_fill_engine #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [7:0] cmd_w,
  input  logic [7:0] cmd_h,
  input  logic [2:0] cmd_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  localparam logic [8:0] W_LIM = 9'(SCREEN_W);
  localparam logic [8:0] H_LIM = 9'(SCREEN_H);

  state_t      state, state_next;
  logic        push, pop, q_full, q_empty;
  logic [34:0] q_rdata;
  logic [7:0]  base_x, base_y, w, h;
  logic [2:0]  col_r;
  logic [7:0]  col, row, col_next, row_next;
  logic [8:0]  sum_x_next, sum_y_next;

  assign cmd_ready = !q_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !q_empty;
  assign busy      = (state != IDLE) || !q_empty;

  rect_fill_queue #(.DEPTH(FIFO_DEPTH), .WIDTH(35)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    case (state)
      IDLE: if (!q_empty) state_next = LOAD;
      LOAD: begin
        col_next   = 8'd0;
        row_next   = 8'd0;
        state_next = (w == 8'd0 || h == 8'd0) ? DONE : SCAN;
      end
      SCAN: begin
        if (col == w - 8'd1) begin
          col_next = 8'd0;
          if (row == h - 8'd1) state_next = DONE;
          else                 row_next   = row + 8'd1;
        end else begin
          col_next = col + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with SCAN cycles.
  assign sum_x_next = {1'b0, base_x} + {1'b0, col_next};
  assign sum_y_next = {1'b0, base_y} + {1'b0, row_next};

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      col    <= 8'd0;
      row    <= 8'd0;
      base_x <= 8'd0;
      base_y <= 8'd0;
      w      <= 8'd0;
      h      <= 8'd0;
      col_r  <= 3'd0;
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
      // Head is captured on the pop edge; its queue slot may be reused by a push during LOAD.
      if (pop) {base_x, base_y, w, h, col_r} <= q_rdata;
      plot <= 1'b0;
      if (state_next == SCAN) begin
        x      <= sum_x_next[7:0];
        y      <= sum_y_next[6:0];
        colour <= col_r;
        plot   <= (sum_x_next < W_LIM) && (sum_y_next < H_LIM);
      end
      done <= (state_next == DONE);
    end
  end
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Downstream drawing stage between the game FSM and vga_adapter.
- Accepts queued rectangle-fill commands (origin, width, height, colour) over a valid/ready handshake.
- Rasterises each command into one pixel write per clock, driving the adapter's x, y, colour and plot inputs.
- Lets the game FSM issue erase and draw operations as single commands instead of running its own draw_counter loops.

Parameters:
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.
- FIFO_DEPTH, 4, command queue depth; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  queue can accept a command
- cmd_x  in  8  rectangle origin x
- cmd_y  in  8  rectangle origin y
- cmd_w  in  8  width in pixels, 0..255
- cmd_h  in  8  height in pixels, 0..255
- cmd_colour  in  3  RGB fill colour
- x  out  8  pixel x to vga_adapter
- y  out  7  pixel y to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  pixel write enable
- busy  out  1  state != IDLE or queue non-empty
- done  out  1  one-cycle pulse per completed command

Behaviour:
- Clock and reset: one clock, reset is synchronous and active-high.
- Reset values: x=0, y=0, colour=0, plot=0, done=0, busy=0, cmd_ready=1, queue empty, state IDLE, col=0, row=0.
- Reset mid-operation: the current command is aborted and the queue is flushed; no further plot pulses occur.
- Push: on an edge with cmd_valid && cmd_ready, the command is written to the queue tail.
- cmd_ready = (count < FIFO_DEPTH), evaluated before any same-cycle pop. A pop never frees space for a push in the same cycle.
- Pop: occurs only on the IDLE->LOAD transition.
- Ordering: strict FIFO; commands are never reordered or merged.
- State IDLE: if the queue is non-empty, pop the head and go to LOAD; otherwise stay in IDLE.
- State LOAD: latch the head into base_x, base_y, w, h, col_r and set col=0, row=0. Go to DONE if w==0 or h==0, else go to SCAN.
- State SCAN: each cycle emits pixel (base_x+col, base_y+row) in row-major order.
  - Step: if col==w-1 then col=0 and row=row+1; otherwise col=col+1.
  - Exit: after the pixel with col==w-1 and row==h-1, go to DONE.
- State DONE: done=1 for exactly this cycle, plot=0, then go to IDLE.
- Outputs are registered and coincide with SCAN cycles: every SCAN cycle drives x, y and colour; plot=0 in all other states.
- Arithmetic: the sums base_x+col and base_y+row are formed at 9 bits, so there is no wrap.
- Clipping: plot=1 only if sum_x < SCREEN_W and sum_y < SCREEN_H. Clipped pixels still take one cycle, so a command always takes w*h SCAN cycles. Output y is sum_y[6:0].
- Latency: with accept edge E0 into an empty, IDLE engine, the state is LOAD after E1 and the first pixel appears after E2.
- Command-to-command gap: the last pixel of one command and the first pixel of the next are separated by exactly 3 non-plot cycles (DONE, IDLE, LOAD).
- Zero-size command: done is asserted after E2 and no plot is generated.
- colour passes cmd_colour through unchanged, including 000 (erase).

Test Plan:
- Paddle fill: cmd (76,110,16,2,111).
  - Expect 32 consecutive plot cycles, first (76,110), 16th (91,110), last (91,111).
  - done=1 on the cycle after the last pixel; busy=0 the cycle after that.
- Zero size: cmd (10,10,0,5,010).
  - Expect no plot and done 2 cycles after the accept edge.
  - Repeat with w=5, h=0 and expect the same result.
- Clipping: cmd (155,118,10,4,100).
  - Expect 40 SCAN cycles with exactly 10 plots (x 155..159, y 118..119).
  - No pixel with x>=160 or y>=120 has plot=1.
- Back-to-back commands: erase (75,30,8,2,000) then draw (75,40,8,2,010), pushed in consecutive cycles.
  - Expect 16 black pixels, 3 gap cycles, then 16 green pixels, with two done pulses.
- Queue full: hold cmd_valid=1 for 6 commands while the first (0,0,160,120) is scanning.
  - The first pops, 4 more queue, and cmd_ready=0 for the 6th until the next pop.
  - No command is lost or duplicated.
- Reset mid-scan: assert reset at pixel 50 of a 16x16 command with 2 queued.
  - Next cycle: plot=0, busy=0, cmd_ready=1; no done pulse and no further pixels.
